// File: rtl/bp_be_rolly_replay_fifo_pkg.sv
// Shared helpers for the rolly replay FIFO.
// Payload packing stays with the instantiator, so no typedefs live here.
package bp_be_rolly_replay_fifo_pkg;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read register file with asynchronous read and no reset.
module bsg_mem_1r1w #(
  parameter int width_p = 64,
  parameter int els_p   = 8,
  localparam int addr_width_lp = $clog2(els_p)
) (
  input  logic                     w_clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge w_clk_i)
    if (w_v_i) mem_r[w_addr_i] <= w_data_i;

  assign r_data_o = mem_r[r_addr_i];

endmodule

// File: rtl/bp_be_rolly_replay_fifo.sv
// Replay FIFO: dequeued entries stay resident until committed; a roll rewinds
// the read pointer to the commit pointer so uncommitted entries replay in order.
module bp_be_rolly_replay_fifo
  import bp_be_rolly_replay_fifo_pkg::*;
#(
  parameter int width_p          = 64,
  parameter int els_p            = 8,
  parameter int max_inflight_p   = els_p,
  parameter int ckpt_width_p     = 2,
  parameter int roll_cnt_width_p = 16
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic [width_p-1:0]          data_i,
  input  logic                        v_i,
  output logic                        ready_o,
  output logic [width_p-1:0]          data_o,
  output logic                        v_o,
  input  logic                        yumi_i,
  input  logic [ckpt_width_p-1:0]     ckpt_n_i,
  input  logic                        roll_v_i,
  input  logic                        clr_v_i,
  output logic [$clog2(els_p+1)-1:0]  inflight_o,
  output logic [$clog2(els_p+1)-1:0]  occupancy_o,
  output logic [roll_cnt_width_p-1:0] roll_count_o
);

  localparam int idx_w_lp = $clog2(els_p);
  localparam int ptr_w_lp = idx_w_lp + 1;
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam int cmp_w_lp = max_int(ckpt_width_p, ptr_w_lp);
  localparam logic [ptr_w_lp-1:0] els_lp    = ptr_w_lp'(els_p);
  localparam logic [ptr_w_lp-1:0] max_if_lp = ptr_w_lp'(max_inflight_p);

  logic [ptr_w_lp-1:0] wptr, rptr, cptr, wptr_n, rptr_n, cptr_n;
  logic [ptr_w_lp-1:0] occupancy, inflight, unread, commit_n;
  logic [cmp_w_lp-1:0] ckpt_ext, inflight_ext;
  logic [roll_cnt_width_p-1:0] roll_cnt;
  logic enq, over_commit, roll_eff;

  assign occupancy = wptr - cptr;
  assign inflight  = rptr - cptr;
  assign unread    = wptr - rptr;

  assign ready_o      = (occupancy != els_lp);
  assign v_o          = (unread != '0) && (inflight < max_if_lp);
  assign enq          = v_i & ready_o;
  assign inflight_o   = cnt_w_lp'(inflight);
  assign occupancy_o  = cnt_w_lp'(occupancy);
  assign roll_count_o = roll_cnt;

  // Commit is limited to entries already in flight at the start of the cycle.
  assign ckpt_ext     = cmp_w_lp'(ckpt_n_i);
  assign inflight_ext = cmp_w_lp'(inflight);
  assign over_commit  = ckpt_ext > inflight_ext;

  always_comb begin
    commit_n = ptr_w_lp'(ckpt_ext);
    if (clr_v_i || over_commit) commit_n = inflight;
    cptr_n = cptr + commit_n;
    rptr_n = rptr;
    if (roll_v_i)    rptr_n = cptr_n;
    else if (yumi_i) rptr_n = rptr + ptr_w_lp'(1);
    wptr_n = enq ? wptr + ptr_w_lp'(1) : wptr;
    // A roll counts if it undoes in-flight entries or swallows a same-cycle yumi.
    roll_eff = roll_v_i & ~clr_v_i & ((cptr_n != rptr) | yumi_i);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr     <= '0;
      rptr     <= '0;
      cptr     <= '0;
      roll_cnt <= '0;
    end else begin
      wptr <= wptr_n;
      rptr <= rptr_n;
      cptr <= cptr_n;
      if (roll_eff && roll_cnt != '1) roll_cnt <= roll_cnt + roll_cnt_width_p'(1);
    end
  end

  bsg_mem_1r1w #(.width_p(width_p), .els_p(els_p)) mem (
    .w_clk_i  (clk_i),
    .w_v_i    (enq),
    .w_addr_i (wptr[idx_w_lp-1:0]),
    .w_data_i (data_i),
    .r_addr_i (rptr[idx_w_lp-1:0]),
    .r_data_o (data_o)
  );

  a_yumi_without_v: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);
  a_over_commit:    assert property (@(posedge clk_i) disable iff (!reset_n_i) !over_commit);
  a_occupancy:      assert property (@(posedge clk_i) disable iff (!reset_n_i) occupancy <= els_lp);

endmodule

// File: tb/tb_bp_be_rolly_replay_fifo.sv
// Bench for the replay FIFO: directed vector table, hand sequences for reset
// and the inflight cap, then random traffic against a queue-based model.
module tb_bp_be_rolly_replay_fifo;

  localparam int W = 64;
  localparam int N = 8;

  logic clk = 0;
  logic reset_n = 1;
  always #5 clk = ~clk;

  logic [W-1:0] data_i = '0, data_o;
  logic v_i = 0, yumi = 0, roll = 0, clr = 0, ready, v_o;
  logic [1:0] ckpt = '0;
  logic [3:0] inflight, occupancy;
  logic [15:0] roll_count;

  bp_be_rolly_replay_fifo #(.width_p(W), .els_p(N)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(data_i), .v_i(v_i), .ready_o(ready),
    .data_o(data_o), .v_o(v_o), .yumi_i(yumi), .ckpt_n_i(ckpt), .roll_v_i(roll),
    .clr_v_i(clr), .inflight_o(inflight), .occupancy_o(occupancy), .roll_count_o(roll_count)
  );

  // Second instance with a capped speculative depth.
  logic [W-1:0] c_data_i = '0, c_data_o;
  logic c_v = 0, c_yumi = 0, c_ready, c_vo;
  logic [1:0] c_ckpt = '0;
  logic [3:0] c_inf, c_occ;
  logic [15:0] c_rc;

  bp_be_rolly_replay_fifo #(.width_p(W), .els_p(N), .max_inflight_p(2)) u_cap (
    .clk_i(clk), .reset_n_i(reset_n), .data_i(c_data_i), .v_i(c_v), .ready_o(c_ready),
    .data_o(c_data_o), .v_o(c_vo), .yumi_i(c_yumi), .ckpt_n_i(c_ckpt), .roll_v_i(1'b0),
    .clr_v_i(1'b0), .inflight_o(c_inf), .occupancy_o(c_occ), .roll_count_o(c_rc)
  );

  int vectors = 0;
  int errors  = 0;

  // Reference model: list of uncommitted entries plus how many of them were handed out.
  logic [W-1:0] mq[$];
  int rd = 0;
  int rc = 0;

  typedef struct {
    logic v; logic [W-1:0] d; logic y; logic [1:0] c; logic r; logic cl;
    logic er; logic ev; logic [W-1:0] ed; int ei; int eo; int erc;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic y,
                              input logic [1:0] c, input logic r, input logic cl,
                              input logic er, input logic ev, input logic [W-1:0] ed,
                              input int ei, input int eo, input int erc);
    vec_t t;
    t.v = v; t.d = d; t.y = y; t.c = c; t.r = r; t.cl = cl;
    t.er = er; t.ev = ev; t.ed = ed; t.ei = ei; t.eo = eo; t.erc = erc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic er, input logic ev,
                           input logic [W-1:0] ed, input int ei, input int eo, input int erc);
    chk({tag, "_ready"}, W'(ready), W'(er));
    chk({tag, "_v"}, W'(v_o), W'(ev));
    chk({tag, "_inflight"}, W'(inflight), W'(ei));
    chk({tag, "_occupancy"}, W'(occupancy), W'(eo));
    chk({tag, "_rollcnt"}, W'(roll_count), W'(erc));
    if (ev) chk({tag, "_data"}, data_o, ed);
  endtask

  task automatic check_model(input string tag);
    logic ev;
    logic [W-1:0] ed;
    ev = (mq.size() - rd) != 0 && rd < N;
    ed = ev ? mq[rd] : '0;
    check_out(tag, mq.size() != N, ev, ed, rd, mq.size(), rc);
  endtask

  task automatic model_update(input logic v, input logic [W-1:0] d, input logic y,
                              input logic [1:0] c, input logic r, input logic cl);
    logic rdy;
    int k;
    rdy = mq.size() != N;
    k = cl ? rd : ((int'(c) < rd) ? int'(c) : rd);
    repeat (k) void'(mq.pop_front());
    rd -= k;
    if (r && !cl && (rd != 0 || y) && rc != 65535) rc++;
    if (r) rd = 0;
    else if (y) rd++;
    if (v && rdy) mq.push_back(d);
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic y,
                       input logic [1:0] c, input logic r, input logic cl);
    v_i = v; data_i = d; yumi = y; ckpt = c; roll = r; clr = cl;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input string tag, input logic v, input logic [W-1:0] d, input logic y,
                      input logic [1:0] c, input logic r, input logic cl);
    drive(v, d, y, c, r, cl);
    #2 check_model(tag);
    @(posedge clk);
    model_update(v, d, y, c, r, cl);
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete(); rd = 0; rc = 0;
  endtask

  initial begin
    // Fill/drain on the default instance.
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1, W'('h10 + k), 0, 0, 0, 0, 1, k > 0, 'h10, 0, k, 0));
    tbl.push_back(mk(1, 'hEE, 0, 0, 0, 0, 0, 1, 'h10, 0, 8, 0));
    for (int j = 0; j < 8; j++) tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1, W'('h10 + j), j, 8, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 8, 8, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 0, 0, 0, 8, 8, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 0, 6, 6, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 0, 4, 4, 0));
    tbl.push_back(mk(0, 0, 0, 2, 0, 0, 1, 0, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // Rollback replay: A,B,C; take A,B; commit A; roll -> B,C again.
    tbl.push_back(mk(1, 'hA, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 'hB, 0, 0, 0, 0, 1, 1, 'hA, 0, 1, 0));
    tbl.push_back(mk(1, 'hC, 0, 0, 0, 0, 1, 1, 'hA, 0, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hA, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hB, 1, 3, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 1, 1, 'hC, 2, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 'hC, 1, 2, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hB, 0, 2, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hC, 1, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 2, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    // Roll with same-cycle yumi: entry replays and the roll counts.
    tbl.push_back(mk(1, 'hA1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1, 0, 1, 1, 'hA1, 0, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'hA1, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    // clr with roll: clear wins, roll not counted.
    tbl.push_back(mk(1, 'h55, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 0, 0, 0, 1, 1, 'h55, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2));

    #1 reset_n = 0;
    #2 check_out("reset", 1, 0, 0, 0, 0, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1;
    model_reset();

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].c, tbl[i].r, tbl[i].cl);
      #2 check_out($sformatf("t%0d", i), tbl[i].er, tbl[i].ev, tbl[i].ed, tbl[i].ei, tbl[i].eo, tbl[i].erc);
      @(posedge clk);
      model_update(tbl[i].v, tbl[i].d, tbl[i].y, tbl[i].c, tbl[i].r, tbl[i].cl);
      @(negedge clk);
    end

    // Async reset with 5 entries held, two of them in flight.
    for (int k = 0; k < 5; k++) step("pre_rst", 1, W'('h60 + k), 0, 0, 0, 0);
    step("pre_rst_y0", 0, 0, 1, 0, 0, 0);
    step("pre_rst_y1", 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 reset_n = 0;
    #1 check_out("async_rst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_n = 1;
    model_reset();
    step("post_rst_enq", 1, 'h77, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    #2 chk("post_rst_data", data_o, 'h77);
    @(negedge clk);
    step("post_rst_y", 0, 0, 1, 0, 0, 0);
    step("post_rst_clr", 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);

    // Inflight cap of 2 on the second instance.
    for (int k = 0; k < 5; k++) begin
      c_v = 1; c_data_i = W'('h30 + k);
      @(negedge clk);
    end
    c_v = 0;
    c_yumi = 1; @(negedge clk); @(negedge clk);
    c_yumi = 0;
    #2 chk("cap_v_low", W'(c_vo), 0);
    chk("cap_inflight", W'(c_inf), 2);
    chk("cap_occ", W'(c_occ), 5);
    @(negedge clk);
    c_ckpt = 1; @(negedge clk);
    c_ckpt = 0;
    #2 chk("cap_v_back", W'(c_vo), 1);
    chk("cap_inflight1", W'(c_inf), 1);
    chk("cap_data", c_data_o, 'h32);
    @(negedge clk);

    // Random protocol-legal traffic; wraps the pointers many times.
    for (int n = 0; n < 600; n++) begin
      logic ev, ry, rr, rcl, rv;
      int maxc;
      ev   = (mq.size() - rd) != 0 && rd < N;
      rv   = ($urandom_range(0, 3) != 0);
      ry   = ev && ($urandom_range(0, 2) != 0);
      rr   = ($urandom_range(0, 9) == 0);
      rcl  = ($urandom_range(0, 14) == 0);
      maxc = (rd < 3) ? rd : 3;
      step($sformatf("r%0d", n), rv, {$urandom, $urandom}, ry,
           2'($urandom_range(0, maxc)), rr, rcl);
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bp_be_rolly_replay_fifo.md
Name: bp_be_rolly_replay_fifo

Overview:
Parametrised replay FIFO that sits between a request source and the BE dcache, successor to the fixed 8-entry single-commit rolly FIFO in the dcache testbenches.
- Holds every dequeued entry until it is committed; a rollback replays all uncommitted entries in order.
- Adds multi-entry commit per cycle, a cap on speculative depth, a commit-all clear, and status/statistics outputs.
- One instance is used per LCE channel.

Parameters:
width_p, 64, payload width in bits (dcache pkt plus ptag).
els_p, 8, entry count; power of 2, at least 2.
max_inflight_p, els_p, maximum number of dequeued-but-uncommitted entries; 1 to els_p.
ckpt_width_p, 2, width of commit count ckpt_n_i; up to 2^ckpt_width_p - 1 entries committed per cycle.
roll_cnt_width_p, 16, width of the rollback statistics counter.

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
data_i  in  width_p  enqueue payload
v_i  in  1  enqueue valid
ready_o  out  1  space available
data_o  out  width_p  head-of-replay payload
v_o  out  1  data_o valid
yumi_i  in  1  dequeue; legal only when v_o
ckpt_n_i  in  ckpt_width_p  number of oldest in-flight entries to commit this cycle; 0 = none
roll_v_i  in  1  rewind read pointer to commit pointer
clr_v_i  in  1  commit all dequeued entries
inflight_o  out  $clog2(els_p+1)  dequeued-but-uncommitted count
occupancy_o  out  $clog2(els_p+1)  entries not yet committed (written minus committed)
roll_count_o  out  roll_cnt_width_p  saturating count of effective rollbacks

Behaviour:
- State:
  - Pointers wptr, rptr, cptr, each $clog2(els_p)+1 bits; the MSB is the wrap bit.
  - occupancy = wptr-cptr; inflight = rptr-cptr; unread = wptr-rptr.
- Reset (reset_n_i low, asynchronous):
  - All pointers and roll_count_o go to 0 immediately; contents are discarded.
  - Outputs during reset: ready_o=1, v_o=0, inflight_o=0, occupancy_o=0, roll_count_o=0.
  - Reset asserted mid-operation behaves identically; no partial commit survives.
- ready_o = (occupancy != els_p).
  - Derived from registered state only; a same-cycle commit does not raise it.
  - Enqueue when v_i & ready_o: mem[wptr] <= data_i, wptr++. Enqueue while full is ignored.
- v_o = (unread != 0) & (inflight < max_inflight_p).
  - data_o = mem[rptr], read combinationally.
  - Write-to-read latency is 1 cycle; there is no bypass.
- Next-state update order within one cycle:
  1. Commit: if clr_v_i, cptr' = rptr. Otherwise cptr' = cptr + min(ckpt_n_i, inflight). clr_v_i overrides ckpt_n_i.
  2. Dequeue: if yumi_i & ~roll_v_i, rptr' = rptr+1.
  3. Roll: if roll_v_i, rptr' = cptr'. A yumi_i in the same cycle is discarded, and that entry replays.
  4. Enqueue, as above.
- Commit counts only entries dequeued in earlier cycles; an entry dequeued this cycle cannot be committed this cycle.
- ckpt_n_i > inflight is a protocol error: assertion fires, and the commit saturates to inflight.
- roll_v_i & clr_v_i together: clear commits everything first, so the roll is a no-op and is not counted.
- roll_count_o increments on roll_v_i only when rptr' != rptr (pre-roll inflight, or a discarded yumi). It saturates at all-ones.
- Wrap-around: pointers wrap modulo 2*els_p. Full is detected by equal index bits with differing wrap bits.
- Assertions, active only while reset_n_i is high:
  - yumi_i without v_o.
  - Over-commit (ckpt_n_i > inflight).
  - occupancy > els_p.

Decomposition:
- No new package typedefs. Payload packing stays with the instantiator, e.g. {ptag, bp_be_dcache_pkt_s}.
- Pointer widths are localparams.
- Storage is one sub-module, bsg_mem_1r1w (els_p x width_p, asynchronous read), instantiated as mem.
- Pointer, commit and statistics logic live in the top module.

Test Plan:
- Fill/drain: els_p=8. Enqueue 8 entries (0x10..0x17), then ready_o=0. Dequeue all, v_o=0. Set ckpt_n_i=2 four times. Required: ready_o rises the cycle after the first commit, occupancy_o goes 8->6->4->2->0.
- Rollback replay: enqueue A,B,C; dequeue A,B; commit 1; roll. Required: next data_o=B, inflight_o=0, roll_count_o=1, then C follows B.
- Roll with same-cycle yumi: enqueue A; assert yumi_i and roll_v_i in the same cycle. Required: A is presented again next cycle, roll_count_o=1.
- Inflight cap: max_inflight_p=2, enqueue 5. Required: v_o drops after 2 dequeues. Commit 1 restores v_o the next cycle.
- clr+roll and wrap: run 20 enqueue/dequeue/clr cycles crossing the wrap boundary twice, with clr_v_i & roll_v_i asserted together once. Required: in-order data, the roll is not counted, and no assertion fires.
- Async reset mid-operation: deassert reset_n_i with 5 entries held. Required: outputs take reset values immediately, without waiting for a clock edge, and data enqueued after release starts at index 0.
